fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-sequencing controller for the PC unit and fetch path. Drives the PC unit's
//  bus gate, load strobe and next-PC select; sequences MAR load, memory read handshake
//  and IR load; dispatches decoded opcodes to branch, jump or execute handling.
//  Sits between the memory interface, the PC unit and the execute datapath.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles in FETCH_WAIT without mem_ready before FAULT (1..255)
//  CNT_W        16  width of retired-instruction counter
// PORTS
//  clk          in   1      clock; all state changes on rising edge
//  reset        in   1      synchronous, active-high reset
//  run          in   1      1 = fetch next instruction; 0 = hold at instruction boundary
//  mem_ready    in   1      memory read data valid (one-cycle pulse or level)
//  opcode       in   4      IR[15:12], valid from DECODE onward
//  nzp_match    in   1      branch condition true (IR nzp & CC), valid in DECODE
//  exec_done    in   1      execute datapath finished current instruction
//  gate_pc      out  1      PC unit bus-drive enable
//  load_pc      out  1      PC unit load strobe
//  pc_sel       out  2      next-PC select: 0 = PC+2, 1 = EA, 2 = bus; 3 never driven
//  load_mar     out  1      latch bus into MAR
//  mem_read     out  1      memory read request
//  load_ir      out  1      latch MDR into IR
//  exec_start   out  1      one-cycle pulse: begin execute of current instruction
//  fault        out  1      sticky: memory timeout or reserved opcode
//  retired      out  CNT_W  count of completed instructions, wraps
//  state        out  3      current state encoding (debug)
// BEHAVIOUR
//  - reset: state=FETCH_ADDR, all strobes 0, pc_sel=0, fault=0, retired=0, timer=0.
//    reset wins over every other input in any state, including mid-FETCH_WAIT.
//  - Outputs are Moore (decoded from state register only); exec_start is registered.
//  - FETCH_ADDR: if run=0 -> stay, all strobes 0. If run=1 -> gate_pc=1, load_mar=1,
//    load_pc=1, pc_sel=0; next FETCH_WAIT, timer cleared.
//  - FETCH_WAIT: mem_read=1. mem_ready=1 -> FETCH_IR. Else timer++; timer reaching
//    MEM_TIMEOUT -> FAULT. mem_ready on the same cycle as timeout wins (-> FETCH_IR).
//  - FETCH_IR: load_ir=1; next DECODE.
//  - DECODE (no strobes): opcode 0000 BR: nzp_match ? BRANCH : retire, FETCH_ADDR.
//    1100 JMP/RET -> JUMP. 1101 reserved -> FAULT. all others -> EXEC, exec_start=1
//    asserted in first EXEC cycle only.
//  - BRANCH: load_pc=1, pc_sel=1; retire; next FETCH_ADDR.
//  - JUMP: load_pc=1, pc_sel=2; retire; next FETCH_ADDR.
//  - EXEC: wait for exec_done (may be high in first EXEC cycle, 1-cycle exec legal);
//    on exec_done retire, next FETCH_ADDR. No timeout in EXEC.
//  - FAULT: fault=1, all strobes 0, stays until reset.
//  - retire = retired <= retired+1 mod 2^CNT_W, on the edge leaving the state.
//  - gate_pc asserted only in FETCH_ADDR; never with another bus driver strobe.
//  - Minimum latency: not-taken BR = 4 cycles, taken BR / JMP = 5 cycles per instr.
//  - run sampled only in FETCH_ADDR; deasserting mid-instruction completes it first.
// STRUCTURE
//  - Shared package pc_ctrl_pkg: state enum (FETCH_ADDR, FETCH_WAIT, FETCH_IR, DECODE,
//    BRANCH, JUMP, EXEC, FAULT), PC_SEL_INC/EA/BUS constants, opcode constants
//    OP_BR, OP_JMP, OP_RSV.
//  - One sub-module: mem_wait_timer (clear, enable, MEM_TIMEOUT compare -> expired).
//  - Top: state register, next-state logic, output decode, retired counter.
// TESTING
//  1 reset held 3 cycles mid-FETCH_WAIT -> state=FETCH_ADDR, fault=0, retired=0, strobes 0.
//  2 run=1, mem_ready 2 cycles after request, opcode=0001, exec_done 1 cycle after
//    exec_start -> sequence ADDR,WAIT,WAIT,IR,DEC,EXEC,EXEC; pc_sel=0; retired=1.
//  3 opcode=0000 nzp_match=1 -> BRANCH cycle load_pc=1 pc_sel=1; nzp_match=0 -> no
//    second load_pc, back to FETCH_ADDR after DECODE; retired increments either way.
//  4 opcode=1100 -> JUMP cycle load_pc=1 pc_sel=2; pc_sel never 3 across whole run.
//  5 mem_ready held 0, MEM_TIMEOUT=15 -> FAULT after 15 WAIT cycles, fault sticky with
//    run toggling; mem_ready on cycle 15 -> FETCH_IR, no fault. opcode=1101 -> FAULT.
//  6 retired preset near 16'hFFFF via 65535 one-cycle instrs (or CNT_W=4 build, 16 instrs)
//    -> wraps to 0; run=0 in FETCH_ADDR -> no strobes, gate_pc=0, state constant.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch/sequencing controller and the PC unit.
// The state enum order fixes the debug encoding seen on the state port.
package pc_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH_ADDR = 3'd0,
      FETCH_WAIT = 3'd1,
      FETCH_IR   = 3'd2,
      DECODE     = 3'd3,
      BRANCH     = 3'd4,
      JUMP       = 3'd5,
      EXEC       = 3'd6,
      FAULT      = 3'd7
   } state_e;

   localparam logic [1:0] PC_SEL_INC = 2'd0;
   localparam logic [1:0] PC_SEL_EA  = 2'd1;
   localparam logic [1:0] PC_SEL_BUS = 2'd2;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_RSV = 4'b1101;

   typedef struct packed {
      logic       gate_pc;
      logic       load_pc;
      logic [1:0] pc_sel;
      logic       load_mar;
      logic       mem_read;
      logic       load_ir;
   } strobes_t;

   localparam strobes_t STROBES_IDLE = '{
      gate_pc:  1'b0,
      load_pc:  1'b0,
      pc_sel:   PC_SEL_INC,
      load_mar: 1'b0,
      mem_read: 1'b0,
      load_ir:  1'b0
   };

   // Successor of DECODE for a given opcode and branch condition.
   function automatic state_e decode_next(input logic [3:0] opcode, input logic nzp_match);
      state_e nxt;
      case (opcode)
         OP_BR:   nxt = nzp_match ? BRANCH : FETCH_ADDR;
         OP_JMP:  nxt = JUMP;
         OP_RSV:  nxt = FAULT;
         default: nxt = EXEC;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/fetch_ctrl_mem_wait_timer.sv
// Counts FETCH_WAIT cycles without mem_ready; expired_o flags the cycle whose
// increment would reach MEM_TIMEOUT.
module mem_wait_timer
   import pc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [7:0] LAST_CNT = 8'(MEM_TIMEOUT - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = 8'd0;
      end else if (enable_i) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = enable_i && (count_q == LAST_CNT);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-sequencing controller: fetch handshake, PC unit strobes, opcode
// dispatch and retired-instruction count. Outputs decode from the state register.
module fetch_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             mem_ready,
   input  logic [3:0]       opcode,
   input  logic             nzp_match,
   input  logic             exec_done,
   output logic             gate_pc,
   output logic             load_pc,
   output logic [1:0]       pc_sel,
   output logic             load_mar,
   output logic             mem_read,
   output logic             load_ir,
   output logic             exec_start,
   output logic             fault,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       state
);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] retired_q;
   logic [CNT_W-1:0] retired_d;
   logic             exec_start_q;
   logic             exec_start_d;
   logic             retire;
   logic             timer_clr;
   logic             timer_en;
   logic             timer_expired;
   strobes_t         strb;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (timer_clr),
      .enable_i  (timer_en),
      .expired_o (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FETCH_ADDR;
         retired_q    <= '0;
         exec_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         retired_q    <= retired_d;
         exec_start_q <= exec_start_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      retire       = 1'b0;
      timer_clr    = 1'b0;
      timer_en     = 1'b0;
      exec_start_d = 1'b0;
      strb         = STROBES_IDLE;

      case (state_q)
         FETCH_ADDR: begin
            timer_clr = 1'b1;
            // run is only looked at here, so a drop mid-instruction finishes it first.
            if (run) begin
               strb.gate_pc  = 1'b1;
               strb.load_mar = 1'b1;
               strb.load_pc  = 1'b1;
               strb.pc_sel   = PC_SEL_INC;
               state_d       = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            strb.mem_read = 1'b1;
            if (mem_ready) begin
               state_d = FETCH_IR;
            end else begin
               timer_en = 1'b1;
               if (timer_expired) begin
                  state_d = FAULT;
               end
            end
         end
         FETCH_IR: begin
            strb.load_ir = 1'b1;
            state_d      = DECODE;
         end
         DECODE: begin
            state_d = decode_next(opcode, nzp_match);
            // A not-taken branch completes here without a PC load cycle.
            if (state_d == FETCH_ADDR) begin
               retire = 1'b1;
            end
            exec_start_d = (state_d == EXEC);
         end
         BRANCH: begin
            strb.load_pc = 1'b1;
            strb.pc_sel  = PC_SEL_EA;
            retire       = 1'b1;
            state_d      = FETCH_ADDR;
         end
         JUMP: begin
            strb.load_pc = 1'b1;
            strb.pc_sel  = PC_SEL_BUS;
            retire       = 1'b1;
            state_d      = FETCH_ADDR;
         end
         EXEC: begin
            if (exec_done) begin
               retire  = 1'b1;
               state_d = FETCH_ADDR;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = FAULT;
         end
      endcase
   end

   assign retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;

   assign gate_pc    = strb.gate_pc;
   assign load_pc    = strb.load_pc;
   assign pc_sel     = strb.pc_sel;
   assign load_mar   = strb.load_mar;
   assign mem_read   = strb.mem_read;
   assign load_ir    = strb.load_ir;
   assign exec_start = exec_start_q;
   assign fault      = (state_q == FAULT);
   assign retired    = retired_q;
   assign state      = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-instruction cycle traces built from the
// instruction-level rules, compared against the outputs every cycle.
module tb_fetch_ctrl;

   localparam int MEM_TO = 15;
   localparam int CW     = 4;

   localparam int P_ADDR = 0, P_WAIT = 1, P_IR = 2, P_DEC = 3;
   localparam int P_BR   = 4, P_JMP = 5, P_EXEC = 6, P_FAULT = 7;

   logic          clk = 1'b0;
   logic          reset, run, mem_ready, nzp_match, exec_done;
   logic [3:0]    opcode;
   logic          gate_pc, load_pc, load_mar, mem_read, load_ir, exec_start, fault;
   logic [1:0]    pc_sel;
   logic [CW-1:0] retired;
   logic [2:0]    state;
   logic [11:0]   obs;

   int total = 0;
   int bad   = 0;
   int model_ret = 0;
   int sel3 = 0;
   int trace[$];

   fetch_ctrl #(.MEM_TIMEOUT(MEM_TO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .opcode(opcode),
      .nzp_match(nzp_match), .exec_done(exec_done), .gate_pc(gate_pc), .load_pc(load_pc),
      .pc_sel(pc_sel), .load_mar(load_mar), .mem_read(mem_read), .load_ir(load_ir),
      .exec_start(exec_start), .fault(fault), .retired(retired), .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {state, gate_pc, load_pc, pc_sel, load_mar, mem_read, load_ir, exec_start, fault};

   always @(negedge clk) if (pc_sel == 2'd3) sel3++;

   function automatic logic [11:0] exp_vec(input int ph, input bit first, input bit r);
      logic g, lp, lm, mr, li, es, f;
      logic [1:0] ps;
      g = 0; lp = 0; lm = 0; mr = 0; li = 0; es = 0; f = 0; ps = 2'd0;
      case (ph)
         P_ADDR:  if (r) begin g = 1; lp = 1; lm = 1; end
         P_WAIT:  mr = 1;
         P_IR:    li = 1;
         P_BR:    begin lp = 1; ps = 2'd1; end
         P_JMP:   begin lp = 1; ps = 2'd2; end
         P_EXEC:  es = first;
         P_FAULT: f = 1;
         default: ;
      endcase
      return {3'(ph), g, lp, ps, lm, mr, li, es, f};
   endfunction

   // L = cycles of waiting before mem_ready (ready in WAIT cycle L+1); E = exec cycles after start.
   task automatic do_instr(input int L, input logic [3:0] op, input logic nzp, input int E,
                           input string tag);
      int nwait, exec_idx;
      bit ret;
      logic [11:0] ev;
      exec_idx = -1;
      ret = 0;
      trace.delete();
      trace.push_back(P_ADDR);
      nwait = (L + 1 > MEM_TO) ? MEM_TO : L + 1;
      repeat (nwait) trace.push_back(P_WAIT);
      if (L + 1 > MEM_TO) begin
         trace.push_back(P_FAULT);
      end else begin
         trace.push_back(P_IR);
         trace.push_back(P_DEC);
         if (op == 4'b0000) begin
            if (nzp) trace.push_back(P_BR);
            ret = 1;
         end else if (op == 4'b1100) begin
            trace.push_back(P_JMP);
            ret = 1;
         end else if (op == 4'b1101) begin
            trace.push_back(P_FAULT);
         end else begin
            exec_idx = trace.size();
            repeat (E + 1) trace.push_back(P_EXEC);
            ret = 1;
         end
      end
      for (int i = 0; i < trace.size(); i++) begin
         @(negedge clk);
         run       = (i == 0) ? 1'b1 : 1'($urandom);
         mem_ready = (i == L + 1) && (i <= nwait);
         exec_done = (exec_idx >= 0) && (i == exec_idx + E);
         opcode    = op;
         nzp_match = nzp;
         #1;
         ev = exp_vec(trace[i], i == exec_idx, run);
         total++;
         if (obs !== ev) begin
            bad++;
            $display("FAIL %s cycle%0d outputs got=%h want=%h", tag, i, obs, ev);
         end
      end
      if (ret) model_ret = (model_ret + 1) % (1 << CW);
      @(posedge clk);
      #1;
      total++;
      if (retired !== CW'(model_ret)) begin
         bad++;
         $display("FAIL %s retired got=%0d want=%0d", tag, retired, model_ret);
      end
   endtask

   task automatic hold_fault(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         run = 1'($urandom);
         mem_ready = 1'($urandom);
         #1;
         total++;
         if (obs !== exp_vec(P_FAULT, 0, run)) begin
            bad++;
            $display("FAIL %s sticky cycle%0d got=%h want=%h", tag, i, obs, exp_vec(P_FAULT, 0, run));
         end
      end
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      reset = 1; run = 0; mem_ready = 0; exec_done = 0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      reset = 0;
      model_ret = 0;
   endtask

   task automatic test_reset();
      do_instr(0, 4'b0000, 1'b0, 0, "pre_reset_br");
      @(negedge clk); run = 1; mem_ready = 0;
      @(negedge clk); run = 0;
      @(negedge clk);
      #1;
      total++;
      if (state !== 3'd1) begin
         bad++;
         $display("FAIL reset_setup state got=%0d want=1", state);
      end
      reset = 1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (obs !== exp_vec(P_ADDR, 0, 0) || retired !== '0) begin
         bad++;
         $display("FAIL reset_state outputs got=%h want=%h retired=%0d", obs, exp_vec(P_ADDR, 0, 0), retired);
      end
      @(negedge clk);
      reset = 0;
      model_ret = 0;
   endtask

   task automatic test_exec();
      do_instr(1, 4'b0001, 1'b0, 1, "exec_basic");
      do_instr(0, 4'b0101, 1'b1, 0, "exec_one_cycle");
      do_instr(3, 4'b1111, 1'b0, 4, "exec_long");
   endtask

   task automatic test_branch();
      do_instr(0, 4'b0000, 1'b1, 0, "br_taken");
      do_instr(0, 4'b0000, 1'b0, 0, "br_not_taken");
      do_instr(2, 4'b0000, 1'b1, 0, "br_taken_slow");
   endtask

   task automatic test_jump();
      do_instr(0, 4'b1100, 1'b0, 0, "jmp");
      do_instr(4, 4'b1100, 1'b1, 0, "jmp_slow");
   endtask

   task automatic test_timeout();
      do_instr(20, 4'b0001, 1'b0, 0, "mem_timeout");
      hold_fault(6, "mem_timeout");
      apply_reset(2);
      do_instr(MEM_TO - 1, 4'b0001, 1'b0, 0, "ready_on_last");
      do_instr(0, 4'b1101, 1'b0, 0, "reserved_op");
      hold_fault(5, "reserved_op");
      apply_reset(1);
   endtask

   task automatic test_idle();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         run = 0;
         mem_ready = 1'($urandom);
         exec_done = 1'($urandom);
         #1;
         total++;
         if (obs !== exp_vec(P_ADDR, 0, 0)) begin
            bad++;
            $display("FAIL idle cycle%0d got=%h want=%h", i, obs, exp_vec(P_ADDR, 0, 0));
         end
      end
   endtask

   task automatic test_wrap();
      apply_reset(1);
      for (int i = 0; i < (1 << CW); i++) do_instr(0, 4'b0000, 1'b0, 0, "wrap_br");
      total++;
      if (retired !== '0) begin
         bad++;
         $display("FAIL wrap retired got=%0d want=0", retired);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] op;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         if (op == 4'b1101) op = 4'b0011;
         do_instr($urandom_range(0, 5), op, 1'($urandom), $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      reset = 1; run = 0; mem_ready = 0; nzp_match = 0; exec_done = 0; opcode = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;
      test_reset();
      test_exec();
      test_branch();
      test_jump();
      test_timeout();
      test_idle();
      test_wrap();
      test_back_to_back();
      total++;
      if (sel3 !== 0) begin
         bad++;
         $display("FAIL pc_sel3 count got=%0d want=0", sel3);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
